// File: rtl/arp_responder.sv
// arp_responder: parses ARP requests for local_ip and streams 60-byte ARP replies, with one pending slot.
module arp_responder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] local_ip,
  input  logic [47:0] local_mac,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_valid,
  output logic [7:0]  tx_arp,
  output logic        tx_arp_en,
  output logic [15:0] req_cnt,
  output logic [15:0] drop_cnt
);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  localparam logic [79:0] HDR = 80'h0806_0001_0800_0604_0001;
  state_t       state;
  logic [5:0]   idx, cnt;
  logic         armed, ok, db, dm, acc, pend_v, hit, start;
  logic [79:0]  cap, pend, src;
  logic [7:0]   mac_b, ip_b, hdr_b;
  logic [479:0] frame, build;
  always_comb begin
    mac_b = 8'(local_mac >> {3'd5 - idx[2:0], 3'b0});
    ip_b  = 8'(local_ip >> {2'd3 - 2'(idx - 6'd38), 3'b0});
    hdr_b = 8'(HDR >> {4'd9 - 4'(idx - 6'd12), 3'b0});
    hit   = idx >= 6'd42 && ok && (db || dm);
    start = (state == IDLE || (state == GAP && cnt[0])) && (pend_v || acc);
    src   = pend_v ? pend : cap;
    build = {src[79:32], local_mac, HDR[79:16], 16'h0002, local_mac, local_ip,
             src[79:32], src[31:0], 144'h0};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx <= '0; armed <= 1'b0; ok <= 1'b0; db <= 1'b0; dm <= 1'b0; acc <= 1'b0;
      cap <= '0; pend <= '0; pend_v <= 1'b0; state <= IDLE; cnt <= '0; frame <= '0;
      tx_arp <= '0; tx_arp_en <= 1'b0; req_cnt <= '0; drop_cnt <= '0;
    end else begin
      acc <= !rx_data_valid && hit;
      if (!rx_data_valid) begin
        armed <= 1'b1; idx <= '0; ok <= 1'b1; db <= 1'b1; dm <= 1'b1;
        req_cnt <= req_cnt + 16'(hit);
      end else if (armed) begin
        idx <= idx + 6'(idx != 6'd63);
        if (idx < 6'd6) begin
          db <= db && rx_data == 8'hFF;
          dm <= dm && rx_data == mac_b;
        end
        if (idx >= 6'd12 && idx <= 6'd21) ok <= ok && rx_data == hdr_b;
        if (idx >= 6'd38 && idx <= 6'd41) ok <= ok && rx_data == ip_b;
        if (idx >= 6'd22 && idx <= 6'd31) cap <= {cap[71:0], rx_data};
      end
      // the slot is freed by a start, so a request landing on the same edge can refill it
      if (start) begin
        pend_v <= pend_v && acc;
        pend <= cap;
      end else if (acc && !pend_v) begin
        pend_v <= 1'b1;
        pend <= cap;
      end else if (acc) drop_cnt <= drop_cnt + 16'(drop_cnt != 16'hFFFF);
      if (start) begin
        state <= SEND; cnt <= '0; tx_arp_en <= 1'b1;
        tx_arp <= build[479:472]; frame <= {build[471:0], 8'h00};
      end else if (state == SEND && cnt == 6'd59) begin
        state <= GAP; cnt <= '0; tx_arp_en <= 1'b0; tx_arp <= '0;
      end else if (state == SEND) begin
        cnt <= cnt + 6'd1; tx_arp <= frame[479:472]; frame <= {frame[471:0], 8'h00};
      end else if (state == GAP) begin
        cnt <= cnt + 6'd1;
        if (cnt[0]) state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_arp_responder.sv
// tb_arp_responder: directed ARP request/reply vectors with hand-computed expectations.
module tb_arp_responder;
  logic        clk = 1'b0, rst_n = 1'b0, rx_data_valid = 1'b0, tx_arp_en;
  logic [31:0] local_ip = 32'hC0A8010A;
  logic [47:0] local_mac = 48'h020000000001;
  logic [7:0]  rx_data = '0, tx_arp;
  logic [15:0] req_cnt, drop_cnt;
  int errors = 0, checks = 0, cyc = 0, ncyc = 0, ci = 0, lowrun = 0, idle_bad = 0;
  int lens[$], rises[$], gaps[$];
  logic [7:0] firsts[$];
  logic [7:0] f [0:63];
  logic [7:0] cur [0:63];
  logic [7:0] last [0:63];
  logic [479:0] ev;
  logic prev_en = 1'b0;

  arp_responder dut (.clk(clk), .rst_n(rst_n), .local_ip(local_ip), .local_mac(local_mac),
    .rx_data(rx_data), .rx_data_valid(rx_data_valid), .tx_arp(tx_arp), .tx_arp_en(tx_arp_en),
    .req_cnt(req_cnt), .drop_cnt(drop_cnt));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_arp_en) begin
      if (!prev_en) begin
        rises.push_back(cyc);
        if (lens.size() > 0) gaps.push_back(lowrun);
        lowrun = 0;
        ci = 0;
      end
      if (ci < 64) cur[ci] = tx_arp;
      ci++;
    end else begin
      if (prev_en) begin
        lens.push_back(ci);
        firsts.push_back(cur[0]);
        last = cur;
      end
      lowrun++;
      if (tx_arp !== 8'h00) idle_bad++;
    end
    prev_en = tx_arp_en;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mk(input logic [47:0] dst, input logic [15:0] et, input logic [47:0] sha,
                    input logic [31:0] spa, input logic [31:0] tpa);
    logic [479:0] v;
    v = {dst, sha, et, 16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0001, sha, spa, 48'h0, tpa, 144'h0};
    for (int i = 0; i < 60; i++) f[i] = v[479 - 8*i -: 8];
    for (int i = 60; i < 64; i++) f[i] = 8'h00;
  endtask

  task automatic send(input int len);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      rx_data_valid = 1'b1;
      rx_data = f[i];
    end
    @(negedge clk);
    rx_data_valid = 1'b0;
    rx_data = 8'h00;
    ncyc = cyc;
  endtask

  task automatic wait_frames(input int n);
    for (int i = 0; i < 400 && lens.size() < n; i++) @(negedge clk);
    check("frame_timeout", 64'(lens.size() >= n), 64'd1);
  endtask

  task automatic wait_bytes(input int n);
    int k = 0;
    for (int i = 0; i < 300 && k < n; i++) begin
      @(negedge clk);
      if (tx_arp_en) k++;
    end
    check("byte_timeout", 64'(k), 64'(n));
  endtask

  initial begin
    int base, g0, f0, mism;
    repeat (4) @(negedge clk);
    check("rst_en", 64'(tx_arp_en), 64'd0);
    check("rst_data", 64'(tx_arp), 64'd0);
    check("rst_req", 64'(req_cnt), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    mk(48'hFFFFFFFFFFFF, 16'h0806, 48'h001122334455, 32'hC0A80114, 32'hC0A8010B);
    send(60);
    mk(48'hFFFFFFFFFFFF, 16'h0800, 48'h001122334455, 32'hC0A80114, 32'hC0A8010A);
    send(60);
    mk(48'hFFFFFFFFFFFF, 16'h0806, 48'h001122334455, 32'hC0A80114, 32'hC0A8010A);
    send(41);
    mk(48'h020000000002, 16'h0806, 48'h001122334455, 32'hC0A80114, 32'hC0A8010A);
    send(60);
    repeat (80) @(negedge clk);
    check("neg_frames", 64'(lens.size()), 64'd0);
    check("neg_req", 64'(req_cnt), 64'd0);

    rst_n = 1'b0;
    mk(48'hFFFFFFFFFFFF, 16'h0806, 48'h001122334455, 32'hC0A80114, 32'hC0A8010A);
    fork
      send(60);
      begin repeat (3) @(negedge clk); rst_n = 1'b1; end
    join
    repeat (80) @(negedge clk);
    check("midframe_frames", 64'(lens.size()), 64'd0);
    check("midframe_req", 64'(req_cnt), 64'd0);

    send(60);
    @(negedge clk);
    check("req_n1", 64'(req_cnt), 64'd1);
    wait_frames(1);
    check("latency", 64'(rises[0]), 64'(ncyc + 2));
    check("len", 64'(lens[0]), 64'd60);
    check("dst", {last[0], last[1], last[2], last[3], last[4], last[5]}, 64'h001122334455);
    check("oper", {last[20], last[21]}, 64'h0002);
    check("tpa", {last[38], last[39], last[40], last[41]}, 64'hC0A80114);
    ev = {48'h001122334455, 48'h020000000001, 80'h0806_0001_0800_0604_0002,
          48'h020000000001, 32'hC0A8010A, 48'h001122334455, 32'hC0A80114, 144'h0};
    mism = 0;
    for (int i = 0; i < 60; i++) if (last[i] !== ev[479 - 8*i -: 8]) mism++;
    check("full_reply", 64'(mism), 64'd0);
    check("req_1", 64'(req_cnt), 64'd1);

    mk(48'h020000000001, 16'h0806, 48'h00AABBCCDDEE, 32'hC0A80115, 32'hC0A8010A);
    send(60);
    wait_frames(2);
    check("unicast_sha", {last[0], last[5], last[32], last[37]}, 64'h00EE00EE);
    send(64);
    wait_frames(3);
    check("padded_len", 64'(lens[2]), 64'd60);
    check("req_3", 64'(req_cnt), 64'd3);
    repeat (10) @(negedge clk);

    base = lens.size();
    g0 = gaps.size();
    f0 = firsts.size();
    for (int k = 0; k < 5; k++) begin
      mk(48'hFFFFFFFFFFFF, 16'h0806, {8'(8'hA0 + k), 40'h0102030405}, 32'hC0A80120, 32'hC0A8010A);
      send(42);
    end
    wait_frames(base + 4);
    repeat (150) @(negedge clk);
    check("burst_frames", 64'(lens.size() - base), 64'd4);
    check("burst_req", 64'(req_cnt), 64'd8);
    check("burst_drop", 64'(drop_cnt), 64'd1);
    for (int k = 1; k < 4; k++) check("burst_gap", 64'(gaps[g0 + k]), 64'd2);
    for (int k = 0; k < 4; k++) check("burst_order", 64'(firsts[f0 + k]), 64'(8'hA0 + k));

    base = lens.size();
    mk(48'hFFFFFFFFFFFF, 16'h0806, 48'h001122334455, 32'hC0A80114, 32'hC0A8010A);
    send(60);
    wait_bytes(10);
    local_ip = 32'hC0A80163;
    wait_frames(base + 1);
    check("ip_old", {last[28], last[29], last[30], last[31]}, 64'hC0A8010A);
    mk(48'hFFFFFFFFFFFF, 16'h0806, 48'h001122334455, 32'hC0A80114, 32'hC0A80163);
    send(60);
    wait_frames(base + 2);
    check("ip_new", {last[28], last[29], last[30], last[31]}, 64'hC0A80163);

    send(60);
    wait_bytes(31);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_en", 64'(tx_arp_en), 64'd0);
    check("rst_mid_req", 64'(req_cnt), 64'd0);
    check("rst_mid_drop", 64'(drop_cnt), 64'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    base = lens.size();
    send(60);
    wait_frames(base + 1);
    check("post_rst_len", 64'(lens[base]), 64'd60);
    check("post_rst_req", 64'(req_cnt), 64'd1);
    check("idle_zero", 64'(idle_bad), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
